// File: rtl/rf_wb_writer.sv
// rf_wb_writer: writeback-port arbiter for the 32x32 register file.
// ALU results always win the write port. LSU results go straight through when
// the port and the FIFO are free, and are queued otherwise. A queued result is
// killed when a younger ALU write targets the same register. The decode stage
// can read pending values through the forwarding outputs.
module rf_wb_writer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ALU_WE,
    input  logic [4:0]      ALU_RD,
    input  logic [XLEN-1:0] ALU_WDATA,
    input  logic            LSU_VALID,
    input  logic [4:0]      LSU_RD,
    input  logic [XLEN-1:0] LSU_WDATA,
    output logic            LSU_READY,
    output logic [4:0]      WNUM,
    output logic [XLEN-1:0] WDATA,
    input  logic [4:0]      RNUM1,
    input  logic [4:0]      RNUM2,
    output logic            FWD1_HIT,
    output logic            FWD2_HIT,
    output logic [XLEN-1:0] FWD1_DATA,
    output logic [XLEN-1:0] FWD2_DATA,
    output logic            PENDING
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]      r_rd  [DEPTH];
    logic [XLEN-1:0] r_dat [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]   r_wp, r_rp;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_wnum;
    logic [XLEN-1:0] r_wdata;

    logic w_ready, w_acc_nz, w_alu, w_empty, w_pop, w_direct, w_push, w_kill_in;

    // READY looks only at the registered count, so a pop in the same cycle
    // never opens a slot early.
    assign w_ready   = !RST && (r_cnt < CW'(DEPTH));
    assign w_acc_nz  = LSU_VALID && w_ready && (LSU_RD != 5'd0);
    assign w_alu     = ALU_WE && (ALU_RD != 5'd0);
    assign w_empty   = (r_cnt == '0);
    assign w_pop     = !w_alu && !w_empty;
    assign w_direct  = !w_alu && w_empty && w_acc_nz;
    assign w_push    = w_acc_nz && !w_direct;
    // An LSU result arriving together with an ALU write is older, so it dies on entry.
    assign w_kill_in = w_alu && (LSU_RD == ALU_RD);

    assign LSU_READY = w_ready;
    assign PENDING   = !w_empty;
    assign WNUM      = r_wnum;
    assign WDATA     = r_wdata;

    // FIFO payload; reset is unnecessary because validity lives in r_vld.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_rd[r_wp]  <= LSU_RD;
            r_dat[r_wp] <= LSU_WDATA;
        end
    end

    // FIFO control, WAW kill and write-port select.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vld   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_wnum  <= 5'd0;
            r_wdata <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu && (r_rd[i] == ALU_RD)) r_vld[i] <= 1'b0;
            end
            if (w_pop)  r_vld[r_rp] <= 1'b0;
            if (w_push) r_vld[r_wp] <= !w_kill_in;
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase

            if (w_alu) begin
                r_wnum  <= ALU_RD;
                r_wdata <= ALU_WDATA;
            end else if (!w_empty) begin
                // A killed head still burns its slot as an idle write.
                r_wnum  <= r_vld[r_rp] ? r_rd[r_rp]  : 5'd0;
                r_wdata <= r_vld[r_rp] ? r_dat[r_rp] : '0;
            end else if (w_direct) begin
                r_wnum  <= LSU_RD;
                r_wdata <= LSU_WDATA;
            end else begin
                r_wnum  <= 5'd0;
                r_wdata <= '0;
            end
        end
    end

    logic [4:0]      w_rn  [2];
    logic            w_hit [2];
    logic [XLEN-1:0] w_fd  [2];

    assign w_rn[0]   = RNUM1;
    assign w_rn[1]   = RNUM2;
    assign FWD1_HIT  = w_hit[0];
    assign FWD2_HIT  = w_hit[1];
    assign FWD1_DATA = w_fd[0];
    assign FWD2_DATA = w_fd[1];

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic [PW-1:0] w_idx;
        // Walk oldest to youngest so the youngest live match wins; fall back to the output register.
        always_comb begin
            w_hit[p] = 1'b0;
            w_fd[p]  = '0;
            w_idx    = r_rp;
            if (w_rn[p] != 5'd0) begin
                for (int k = 0; k < DEPTH; k++) begin
                    w_idx = r_rp + PW'(k);
                    if ((CW'(k) < r_cnt) && r_vld[w_idx] && (r_rd[w_idx] == w_rn[p])) begin
                        w_hit[p] = 1'b1;
                        w_fd[p]  = r_dat[w_idx];
                    end
                end
                if (!w_hit[p] && (r_wnum == w_rn[p])) begin
                    w_hit[p] = 1'b1;
                    w_fd[p]  = r_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_writer.sv
// Bench for rf_wb_writer: directed stimulus pushes expected writes into a
// scoreboard; a negedge monitor pops one entry per non-zero WNUM it sees.
module tb_rf_wb_writer;
    localparam int XLEN = 32;

    logic            CLK = 1'b0;
    logic            RST;
    logic            ALU_WE;
    logic [4:0]      ALU_RD;
    logic [XLEN-1:0] ALU_WDATA;
    logic            LSU_VALID;
    logic [4:0]      LSU_RD;
    logic [XLEN-1:0] LSU_WDATA;
    logic            LSU_READY;
    logic [4:0]      WNUM;
    logic [XLEN-1:0] WDATA;
    logic [4:0]      RNUM1, RNUM2;
    logic            FWD1_HIT, FWD2_HIT;
    logic [XLEN-1:0] FWD1_DATA, FWD2_DATA;
    logic            PENDING;

    rf_wb_writer #(.DEPTH(2), .XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST),
        .ALU_WE(ALU_WE), .ALU_RD(ALU_RD), .ALU_WDATA(ALU_WDATA),
        .LSU_VALID(LSU_VALID), .LSU_RD(LSU_RD), .LSU_WDATA(LSU_WDATA),
        .LSU_READY(LSU_READY), .WNUM(WNUM), .WDATA(WDATA),
        .RNUM1(RNUM1), .RNUM2(RNUM2),
        .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT),
        .FWD1_DATA(FWD1_DATA), .FWD2_DATA(FWD2_DATA),
        .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    int n_tot  = 0;
    int n_pass = 0;
    logic [4+XLEN-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expw(input logic [4:0] rd, input logic [XLEN-1:0] d);
        exp_q.push_back({rd, d});
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic alu(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] d);
        ALU_WE = we; ALU_RD = rd; ALU_WDATA = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
        LSU_VALID = v; LSU_RD = rd; LSU_WDATA = d;
    endtask

    // Scoreboard monitor: every real write must match the next expected one.
    always @(negedge CLK) begin
        logic [4+XLEN-1:0] e;
        if (!RST && WNUM != 5'd0) begin
            n_tot++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got rd %0d data %0h expected no write", WNUM, WDATA);
            end else begin
                e = exp_q.pop_front();
                if ({WNUM, WDATA} === e) n_pass++;
                else $display("FAIL write_order: got rd %0d data %0h expected rd %0d data %0h",
                              WNUM, WDATA, e[4+XLEN-1:XLEN], e[XLEN-1:0]);
            end
        end
    end

    initial begin
        RST = 1'b1;
        alu(0, 0, 0); lsu(0, 0, 0);
        RNUM1 = 0; RNUM2 = 0;

        // 1: reset state, then release mid-cycle
        #2;
        chk("rst_wnum", WNUM, 0);
        chk("rst_wdata", WDATA, 0);
        chk("rst_ready", LSU_READY, 0);
        chk("rst_pending", PENDING, 0);
        @(posedge CLK); #3;
        RST = 1'b0;
        #1;
        chk("rel_ready", LSU_READY, 1);

        // 2: ALU only
        alu(1, 5, 32'hDEADBEEF); expw(5, 32'hDEADBEEF);
        cyc();
        chk("alu_wnum", WNUM, 5);
        alu(1, 0, 32'h12345678);
        cyc();
        chk("alu_x0_wnum", WNUM, 0);
        chk("alu_x0_wdata", WDATA, 0);

        // 3: ALU/LSU collision
        alu(1, 3, 32'h11); lsu(1, 4, 32'h22);
        expw(3, 32'h11); expw(4, 32'h22);
        RNUM1 = 4;
        cyc();
        alu(0, 0, 0); lsu(0, 0, 0);
        chk("col_pending", PENDING, 1);
        chk("col_fwd_hit", FWD1_HIT, 1);
        chk("col_fwd_data", FWD1_DATA, 32'h22);
        cyc();
        chk("col_drain_pending", PENDING, 0);
        chk("col_fwd_wnum_data", {FWD1_HIT, FWD1_DATA}, {1'b1, 32'h22});
        RNUM1 = 0;
        #1;
        chk("fwd_x0_nohit", {FWD1_HIT, FWD1_DATA}, 0);

        // 4: backpressure with DEPTH=2
        expw(1, 32'h101); expw(2, 32'h102); expw(3, 32'h103);
        expw(8, 32'hA0);  expw(9, 32'hA1);  expw(10, 32'hA2);
        alu(1, 1, 32'h101); lsu(1, 8, 32'hA0);
        cyc();
        alu(1, 2, 32'h102); lsu(1, 9, 32'hA1);
        cyc();
        alu(1, 3, 32'h103); lsu(1, 10, 32'hA2);
        chk("bp_full_ready", LSU_READY, 0);
        cyc();
        alu(0, 0, 0);
        chk("bp_full_pop_ready", LSU_READY, 0);
        cyc();
        chk("bp_ready_again", LSU_READY, 1);
        cyc();
        lsu(0, 0, 0);
        cyc();
        chk("bp_drained", PENDING, 0);

        // 5: WAW kill of a queued entry
        expw(1, 32'h201); expw(7, 32'hBB);
        alu(1, 1, 32'h201); lsu(1, 7, 32'hAA);
        cyc();
        alu(1, 7, 32'hBB); lsu(0, 0, 0);
        cyc();
        alu(0, 0, 0);
        RNUM2 = 7;
        #1;
        chk("waw_pending", PENDING, 1);
        chk("waw_fwd", {FWD2_HIT, FWD2_DATA}, {1'b1, 32'hBB});
        cyc();
        chk("waw_kill_wnum", WNUM, 0);
        chk("waw_kill_wdata", WDATA, 0);
        chk("waw_kill_pending", PENDING, 0);
        cyc();
        chk("waw_fwd_gone", {FWD2_HIT, FWD2_DATA}, 0);
        RNUM2 = 0;

        // 5b: concurrent kill of the LSU result accepted the same cycle
        expw(6, 32'hC1);
        alu(1, 6, 32'hC1); lsu(1, 6, 32'hC2);
        RNUM1 = 6;
        cyc();
        alu(0, 0, 0); lsu(0, 0, 0);
        chk("ckill_pending", PENDING, 1);
        chk("ckill_fwd", {FWD1_HIT, FWD1_DATA}, {1'b1, 32'hC1});
        cyc();
        chk("ckill_wnum", WNUM, 0);
        chk("ckill_drain", PENDING, 0);
        RNUM1 = 0;

        // 5c: LSU result to x0 is discarded
        lsu(1, 0, 32'hEE);
        cyc();
        lsu(0, 0, 0);
        chk("lsu_x0_wnum", WNUM, 0);
        chk("lsu_x0_pending", PENDING, 0);

        // 6: reset mid-drain
        expw(1, 32'h301);
        alu(1, 1, 32'h301); lsu(1, 11, 32'h311);
        cyc();
        alu(1, 2, 32'h302); lsu(1, 12, 32'h312);
        cyc();
        alu(0, 0, 0); lsu(0, 0, 0);
        chk("md_pending_pre", PENDING, 1);
        #2 RST = 1'b1;
        #1;
        chk("md_rst_wnum", WNUM, 0);
        chk("md_rst_wdata", WDATA, 0);
        chk("md_rst_pending", PENDING, 0);
        chk("md_rst_ready", LSU_READY, 0);
        RST = 1'b0;
        #1;
        chk("md_rel_ready", LSU_READY, 1);
        for (int i = 0; i < 4; i++) cyc();
        chk("md_idle_pending", PENDING, 0);
        chk("md_idle_wnum", WNUM, 0);

        @(negedge CLK); #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/rf_wb_writer.md
Name: rf_wb_writer

Overview:
- Writeback-side writer for the 32x32 register file: merges single-cycle ALU results with variable-latency load/store-unit results into the file's single write port (WNUM/WDATA).
- WNUM=0 means "no write", matching the register-file convention that x0 is never written.
- Buffers LSU results when the ALU holds the port, kills stale queued results on write-after-write to the same register, and forwards pending values to decode-stage readers.

Parameters:
- DEPTH, 2, LSU result FIFO entries (power of 2, >=2)
- XLEN, 32, data width

Ports:
- CLK  in  1  clock; all state on posedge
- RST  in  1  reset, asynchronous, active-high
- ALU_WE  in  1  ALU result valid; always accepted, no backpressure
- ALU_RD  in  5  ALU destination register
- ALU_WDATA  in  XLEN  ALU result
- LSU_VALID  in  1  LSU result valid
- LSU_RD  in  5  LSU destination register
- LSU_WDATA  in  XLEN  LSU result
- LSU_READY  out  1  writer can accept an LSU result this cycle
- WNUM  out  5  registered register-file write index; 0 = idle
- WDATA  out  XLEN  registered register-file write data
- RNUM1, RNUM2  in  5  decode read indices for forwarding lookup
- FWD1_HIT, FWD2_HIT  out  1  pending write to RNUMx exists (combinational)
- FWD1_DATA, FWD2_DATA  out  XLEN  forwarded value; 0 when no hit
- PENDING  out  1  FIFO non-empty

Behaviour:
- Reset (async, immediate):
  - WNUM=0, WDATA=0.
  - FIFO emptied; all entries invalid.
  - PENDING=0, LSU_READY=0 while RST=1.
  - Queued data is never written.
- LSU_READY = !RST && (count < DEPTH), from the registered count only. When full, READY=0 even if a pop occurs that cycle.
- LSU accept = LSU_VALID && LSU_READY. An accepted LSU with LSU_RD=0 is discarded (no enqueue).
- ALU write = ALU_WE && ALU_RD!=0.
- Output-register select each posedge, in priority order:
  1. ALU write -> WNUM<=ALU_RD, WDATA<=ALU_WDATA.
  2. Else FIFO non-empty -> pop head. Valid head: WNUM<=rd, WDATA<=data. Killed head: WNUM<=0, WDATA<=0, still consumes the cycle.
  3. Else accepted LSU with FIFO empty -> direct path, WNUM<=LSU_RD, WDATA<=LSU_WDATA (1-cycle latency, not enqueued).
  4. Else WNUM<=0, WDATA<=0.
- An accepted LSU not taking the direct path is enqueued at the tail.
- Push and pop in the same cycle are both legal.
- WAW kill:
  - Contract: any LSU result present or queued is older in program order than a concurrent ALU write.
  - On an ALU write to rd X, every valid FIFO entry with rd X is invalidated the same cycle.
  - An LSU result accepted that cycle with rd X is also invalidated: it still enqueues, marked killed.
  - Killed entries keep their slot and count until popped.
- LSU results leave in acceptance order; FIFO pointers wrap modulo DEPTH.
- Forwarding for each x in {1,2}:
  - RNUMx=0 -> no hit.
  - Otherwise, the youngest valid FIFO entry with rd==RNUMx wins.
  - Else, if WNUM==RNUMx, hit with WDATA.
  - Else no hit, data 0.
  - The combinational path uses registered state only; there is no loop through ALU/LSU inputs.
- PENDING = count!=0. Killed entries count as pending.

Test Plan:
1. Reset: assert RST mid-cycle -> WNUM=0, WDATA=0, LSU_READY=0, PENDING=0 without waiting for an edge. Release -> LSU_READY=1 next evaluation.
2. ALU only: ALU_WE=1, RD=5, DATA=0xDEADBEEF -> after the edge WNUM=5, WDATA=0xDEADBEEF. Next cycle with RD=0 -> WNUM=0, WDATA=0.
3. Collision: same cycle ALU rd3=0x11 and LSU rd4=0x22 -> edge 1: WNUM=3, PENDING=1, RNUM1=4 gives FWD1_HIT=1, FWD1_DATA=0x22. Edge 2: WNUM=4, WDATA=0x22, PENDING=0.
4. Backpressure: ALU_WE=1 every cycle (rd 1, 2, ...) while LSU pushes rd8=0xA0, then rd9=0xA1 -> LSU_READY=0 with third LSU held. Drop ALU_WE -> WNUM 8, 9, then the held third LSU, in order.
5. WAW kill: queue LSU rd7=0xAA behind ALU traffic, then ALU rd7=0xBB -> WNUM=7/WDATA=0xBB exactly once. The killed entry yields one WNUM=0 cycle; 0xAA is never written. RNUM2=7 forwards 0xBB.
6. Reset mid-drain: 2 entries queued, 1-cycle RST pulse between edges -> WNUM=0 immediately, PENDING=0, neither queued value ever appears on WNUM/WDATA.
